rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: Ethernet receive framing controller.
//
// Finds the preamble/SFD on the PHY byte stream, forwards the frame body (FCS
// included) to a CRC checker and to a downstream consumer, and reports a
// per-frame verdict built from PHY errors, length limits and the CRC result.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   8  PHY receive byte
//   rx_dv      in   1  PHY data valid (high for the whole frame incl. preamble)
//   rx_er      in   1  PHY receive error
//   crc_data   out  8  byte to the CRC checker
//   crc_valid  out  1  crc_data qualifier
//   crc_last   out  1  end-of-frame strobe to the CRC checker (also re-inits it)
//   crc_error  in   1  registered CRC verdict, valid the cycle after crc_last
//   out_data   out  8  payload byte to downstream
//   out_valid  out  1  out_data qualifier
//   out_last   out  1  end marker, asserted with out_valid=0
//   frame_good out  1  one-cycle pulse: frame accepted
//   frame_bad  out  1  one-cycle pulse: frame rejected
//   err_code   out  2  0 none, 1 CRC, 2 length, 3 PHY; held between pulses
//   frame_len  out  11 byte count of the last frame (saturating); held
module rx_frame_ctrl #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  crc_data,
  output logic        crc_valid,
  output logic        crc_last,
  input  logic        crc_error,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [1:0]  err_code,
  output logic [10:0] frame_len
);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StCheck,
    StDrop
  } state_e;

  localparam logic [7:0]  PreambleByte = 8'h55;
  localparam logic [7:0]  SfdByte      = 8'hD5;
  localparam logic [10:0] CntSat       = 11'h7FF;
  // Byte count at which a frame is declared oversized and truncated.
  localparam int unsigned OvfLen       = MAX_LEN + 1;

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrCrc  = 2'd1;
  localparam logic [1:0] ErrLen  = 2'd2;
  localparam logic [1:0] ErrPhy  = 2'd3;

  state_e      state_q;
  logic [10:0] byte_cnt_q;
  logic        phy_err_q;
  logic        len_err_q;
  // End-of-frame strobe cycle in DATA; the CRC verdict is only valid one
  // cycle after crc_last, so CHECK follows this cycle.
  logic        fin_q;
  // Truncated frame still owes its crc_last/out_last strobe.
  logic        ovf_last_q;

  logic [10:0] cnt_inc;

  always_comb begin
    cnt_inc = (byte_cnt_q == CntSat) ? byte_cnt_q : byte_cnt_q + 11'd1;
  end

  // Verdict priority: PHY error, then length, then CRC.
  function automatic logic [1:0] status_code(input logic        phy,
                                             input logic        len,
                                             input logic [10:0] cnt,
                                             input logic        crc);
    if (phy) begin
      return ErrPhy;
    end else if (len || (32'(cnt) < MIN_LEN)) begin
      return ErrLen;
    end else if (crc) begin
      return ErrCrc;
    end
    return ErrNone;
  endfunction

  logic [1:0] chk_code;
  logic [1:0] drop_code;

  always_comb begin
    chk_code  = status_code(phy_err_q, len_err_q, byte_cnt_q, crc_error);
    // An oversized frame is reported without waiting on the CRC checker.
    drop_code = status_code(phy_err_q, 1'b1, byte_cnt_q, 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      phy_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      fin_q      <= 1'b0;
      ovf_last_q <= 1'b0;
      crc_data   <= '0;
      crc_valid  <= 1'b0;
      crc_last   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      err_code   <= '0;
      frame_len  <= '0;
    end else begin
      // Strobes default low; data outputs hold their last value.
      crc_valid  <= 1'b0;
      out_valid  <= 1'b0;
      crc_last   <= 1'b0;
      out_last   <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (rx_dv) begin
            state_q <= (rx_data == PreambleByte) ? StPreamble : StDrop;
          end
        end

        StPreamble: begin
          if (!rx_dv) begin
            state_q <= StIdle;
          end else if (rx_data == PreambleByte) begin
            state_q <= StPreamble;
          end else if (rx_data == SfdByte) begin
            state_q    <= StData;
            byte_cnt_q <= '0;
            phy_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            fin_q      <= 1'b0;
            ovf_last_q <= 1'b0;
          end else begin
            state_q <= StDrop;
          end
        end

        StData: begin
          if (fin_q) begin
            // Strobe cycle done; any rx_dv here belongs to no frame.
            fin_q   <= 1'b0;
            state_q <= StCheck;
          end else if (!rx_dv) begin
            crc_last <= 1'b1;
            out_last <= 1'b1;
            fin_q    <= 1'b1;
          end else begin
            crc_data   <= rx_data;
            out_data   <= rx_data;
            crc_valid  <= 1'b1;
            out_valid  <= 1'b1;
            byte_cnt_q <= cnt_inc;
            if (rx_er) begin
              phy_err_q <= 1'b1;
            end
            if (32'(cnt_inc) == OvfLen) begin
              len_err_q  <= 1'b1;
              ovf_last_q <= 1'b1;
              state_q    <= StDrop;
            end
          end
        end

        StCheck: begin
          frame_good <= (chk_code == ErrNone);
          frame_bad  <= (chk_code != ErrNone);
          err_code   <= chk_code;
          frame_len  <= byte_cnt_q;
          state_q    <= rx_dv ? StDrop : StIdle;
        end

        StDrop: begin
          if (ovf_last_q) begin
            crc_last   <= 1'b1;
            out_last   <= 1'b1;
            ovf_last_q <= 1'b0;
          end
          if (!rx_dv) begin
            state_q <= StIdle;
            if (len_err_q) begin
              frame_good <= 1'b0;
              frame_bad  <= 1'b1;
              err_code   <= drop_code;
              frame_len  <= byte_cnt_q;
              len_err_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomised scoreboard bench for rx_frame_ctrl. Stimulus pushes the expected
// beats, end strobe and verdict of each frame; a negedge monitor pops them as
// the DUT presents outputs. A small CRC-32 checker model answers crc_last.
module tb_rx_frame_ctrl;

  localparam int MinLen = 64;
  localparam int MaxLen = 1518;

  localparam int KBeat = 0;
  localparam int KLast = 1;
  localparam int KStat = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic [1:0]  code;
    logic [10:0] len;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  crc_data;
  logic        crc_valid;
  logic        crc_last;
  logic        crc_error;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        frame_good;
  logic        frame_bad;
  logic [1:0]  err_code;
  logic [10:0] frame_len;

  int    total = 0;
  int    bad = 0;
  item_t exp_q[$];
  bq_t   cbuf;
  logic  prev_valid = 1'b0;

  rx_frame_ctrl #(
    .MIN_LEN (MinLen),
    .MAX_LEN (MaxLen)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .crc_data   (crc_data),
    .crc_valid  (crc_valid),
    .crc_last   (crc_last),
    .crc_error  (crc_error),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .frame_good (frame_good),
    .frame_bad  (frame_bad),
    .err_code   (err_code),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t q, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic logic fcs_ok(input bq_t q);
    logic [31:0] c;
    int          n;
    n = q.size();
    if (n < 4) return 1'b0;
    c = crc32(q, n - 4);
    return c == {q[n-1], q[n-2], q[n-3], q[n-4]};
  endfunction

  // Body of n bytes: random data followed by its FCS, least significant byte first.
  function automatic bq_t make_frame(input int n);
    bq_t         p;
    logic [31:0] c;
    for (int i = 0; i < n - 4; i++) p.push_back(8'($urandom));
    c = crc32(p, n - 4);
    p.push_back(c[7:0]);
    p.push_back(c[15:8]);
    p.push_back(c[23:16]);
    p.push_back(c[31:24]);
    return p;
  endfunction

  function automatic bq_t flip_bit(input bq_t p);
    bq_t q;
    int  k;
    q = p;
    k = $urandom_range(0, q.size() - 5);
    q[k] = q[k] ^ 8'(1 << $urandom_range(0, 7));
    return q;
  endfunction

  // Reference model: what a frame that reached the SFD must produce.
  task automatic expect_frame(input bq_t f, input int er_idx, input bit crc_ok);
    item_t it;
    int    n;
    int    fwd;
    n   = f.size();
    fwd = (n > MaxLen) ? MaxLen + 1 : n;
    for (int i = 0; i < fwd; i++) begin
      it = '{kind: KBeat, data: f[i], code: 2'd0, len: 11'd0};
      exp_q.push_back(it);
    end
    it = '{kind: KLast, data: 8'h00, code: 2'd0, len: 11'd0};
    exp_q.push_back(it);
    it.kind = KStat;
    if (er_idx >= 0 && er_idx < fwd)       it.code = 2'd3;
    else if (n < MinLen || n > MaxLen)     it.code = 2'd2;
    else if (!crc_ok)                      it.code = 2'd1;
    else                                   it.code = 2'd0;
    it.len = (fwd > 2047) ? 11'd2047 : 11'(fwd);
    exp_q.push_back(it);
  endtask

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_dv   = dv;
    rx_er   = er;
  endtask

  task automatic send_frame(input int pre, input bq_t f, input int er_idx, input int gap);
    for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < f.size(); i++) drive(f[i], 1'b1, (i == er_idx));
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_raw(input bq_t b, input int gap);
    for (int i = 0; i < b.size(); i++) drive(b[i], 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, 64'({crc_data, crc_valid, crc_last, out_data, out_valid, out_last,
                     frame_good, frame_bad, err_code, frame_len}), 64'(0));
  endtask

  // CRC checker model: verdict registered on the crc_last edge, low otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_error <= 1'b0;
      cbuf.delete();
    end else begin
      if (crc_valid) cbuf.push_back(crc_data);
      if (crc_last) begin
        crc_error <= !fcs_ok(cbuf);
        cbuf.delete();
      end else begin
        crc_error <= 1'b0;
      end
    end
  end

  // Monitor: pops expected items in beat / last / status order.
  always @(negedge clk) begin : monitor
    item_t it;
    if (rst_n) begin
      if (crc_valid || out_valid) begin
        if (exp_q.size() != 0 && exp_q[0].kind == KBeat) begin
          it = exp_q.pop_front();
          check("beat", 64'({crc_valid, out_valid, crc_data, out_data}),
                64'({2'b11, it.data, it.data}));
        end else begin
          check("unexpected_beat", 64'({crc_valid, out_valid, crc_data}), 64'(0));
        end
      end
      if (crc_last || out_last) begin
        // Strobe pair, no data qualifier, directly after the final beat.
        check("last_strobe", 64'({crc_last, out_last, crc_valid, out_valid, prev_valid}),
              64'(5'b11001));
        if (exp_q.size() != 0 && exp_q[0].kind == KLast) begin
          it = exp_q.pop_front();
        end else begin
          check("unexpected_last", 64'({crc_last, out_last}), 64'(0));
        end
      end
      if (frame_good || frame_bad) begin
        if (exp_q.size() != 0 && exp_q[0].kind == KStat) begin
          it = exp_q.pop_front();
          check("status", 64'({frame_good, frame_bad, err_code, frame_len}),
                64'({(it.code == 2'd0), (it.code != 2'd0), it.code, it.len}));
        end else begin
          check("unexpected_status", 64'({frame_good, frame_bad, err_code}), 64'(0));
        end
      end
    end
    prev_valid = rst_n ? crc_valid : 1'b0;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bq_t f;
    bq_t g;
    bq_t r;
    int  n;
    int  er;
    int  lens[4];

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_outputs");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(8'h00, 1'b0, 1'b0);

    // Minimum-length good frame, then the same frame with one bit flipped.
    f = make_frame(64);
    expect_frame(f, -1, 1'b1);
    send_frame(7, f, -1, 12);
    g = flip_bit(f);
    expect_frame(g, -1, 1'b0);
    send_frame(7, g, -1, 12);

    // Runt frame with correct FCS.
    f = make_frame(60);
    expect_frame(f, -1, 1'b1);
    send_frame(7, f, -1, 12);

    // Oversized frame: truncated after MAX_LEN+1 bytes.
    f = make_frame(1600);
    expect_frame(f, -1, 1'b1);
    send_frame(7, f, -1, 12);

    // PHY error on byte 20 of a good frame.
    f = make_frame(100);
    expect_frame(f, 20, 1'b1);
    send_frame(7, f, 20, 12);

    // Reset at byte 30: bytes 0..29 already forwarded, nothing after.
    f.delete();
    for (int i = 0; i < 64; i++) f.push_back(8'(i + 1));
    for (int i = 0; i < 30; i++) begin
      item_t it;
      it = '{kind: KBeat, data: f[i], code: 2'd0, len: 11'd0};
      exp_q.push_back(it);
    end
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i <= 30; i++) drive(f[i], 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_frame_reset_outputs");
    check("mid_frame_reset_drain", 64'(exp_q.size()), 64'(0));
    drive(f[31], 1'b1, 1'b0);
    drive(f[32], 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 33; i < 64; i++) drive(f[i], 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0);
    f = make_frame(80);
    expect_frame(f, -1, 1'b1);
    send_frame(7, f, -1, 12);

    // No preamble: dropped silently.
    r.delete();
    r.push_back(8'hAA);
    r.push_back(8'h55);
    r.push_back(8'hD5);
    for (int i = 0; i < 70; i++) r.push_back(8'($urandom));
    send_raw(r, 12);

    // Corrupt preamble: dropped silently.
    r.delete();
    r.push_back(8'h55);
    r.push_back(8'h55);
    r.push_back(8'h12);
    r.push_back(8'hD5);
    for (int i = 0; i < 70; i++) r.push_back(8'($urandom));
    send_raw(r, 12);

    // Preamble cut short by rx_dv falling.
    r.delete();
    for (int i = 0; i < 3; i++) r.push_back(8'h55);
    send_raw(r, 6);

    // Second frame starts while the first is still being judged: discarded.
    f = make_frame(70);
    g = make_frame(70);
    expect_frame(f, -1, 1'b1);
    send_frame(7, f, -1, 1);
    send_frame(7, g, -1, 12);

    // Length boundaries.
    lens = '{MinLen - 1, MinLen, MaxLen, MaxLen + 1};
    foreach (lens[k]) begin
      f = make_frame(lens[k]);
      expect_frame(f, -1, 1'b1);
      send_frame(7, f, -1, 12);
    end

    // Randomised frames.
    for (int t = 0; t < 24; t++) begin
      n = int'($urandom_range(48, 180));
      f = make_frame(n);
      if ($urandom_range(0, 3) == 0) begin
        f = flip_bit(f);
        g = f;
      end else begin
        g.delete();
      end
      er = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      expect_frame(f, er, g.size() == 0);
      send_frame(int'($urandom_range(1, 7)), f, er, int'($urandom_range(3, 15)));
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("final_drain", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
